shared_unit_arbiter: RTL and testbench

SHARED_UNIT_ARBITER -- requirements
Module: shared_unit_arbiter

---
 rtl/shared_unit_arbiter.sv | 137 +++++++++++++
 tb/tb_shared_unit_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_unit_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : shared_unit_arbiter                                             |
// | Purpose  : Round-robin arbiter for three masters sharing one unit (adder   |
// |            or exception checker). It grants one master at a time, drives   |
// |            the unit request and the operand-mux select, and returns a      |
// |            one-cycle completion (M_ack) or timeout-abort (M_err) pulse.    |
// | Ports    : CLK     - clock, rising edge                                    |
// |            RST     - asynchronous active-high reset                        |
// |            M_req   - [2:0] per-master level request                        |
// |            M_ack   - [2:0] per-master one-cycle completion pulse           |
// |            M_err   - [2:0] per-master one-cycle timeout-abort pulse        |
// |            GNT     - [2:0] one-hot current owner, zero when no owner       |
// |            S_req   - request to the shared unit                            |
// |            S_ack   - shared-unit done pulse                                |
// |            Select  - [1:0] operand-mux select (owner index)                |
// |            BUSY    - high whenever the arbiter is not idle                 |
// | Params   : TIMEOUT - max cycles to wait for S_ack (legal range 2..255)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module shared_unit_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] M_req,
  output logic [2:0] M_ack,
  output logic [2:0] M_err,
  output logic [2:0] GNT,
  output logic       S_req,
  input  logic       S_ack,
  output logic [1:0] Select,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Wait-counter value on the last SERVE cycle before the transaction aborts.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;        // highest-priority master for the next grant
  logic [7:0] wait_cnt;   // SERVE cycles elapsed without S_ack
  logic [1:0] win_idx;    // round-robin winner among current requests
  logic [2:0] cand;       // candidate index, ptr + offset before wrapping

  // Walk the candidates from lowest to highest priority so the one that is
  // assigned last (offset 0, i.e. ptr itself) wins when several request.
  always_comb begin
    win_idx = ptr;
    cand    = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (M_req[cand[1:0]]) begin
        win_idx = cand[1:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      wait_cnt <= 8'd0;
      S_req    <= 1'b0;
      M_ack    <= 3'b000;
      M_err    <= 3'b000;
      GNT      <= 3'b000;
      Select   <= 2'd0;
      BUSY     <= 1'b0;
    end else begin
      // Response pulses last exactly one cycle.
      M_ack <= 3'b000;
      M_err <= 3'b000;

      case (state)
        IDLE: begin
          // Select keeps its previous value until the next grant.
          if (|M_req) begin
            state    <= SERVE;
            BUSY     <= 1'b1;
            GNT      <= 3'b001 << win_idx;
            Select   <= win_idx;
            S_req    <= 1'b1;
            wait_cnt <= 8'd0;
          end
        end

        SERVE: begin
          // The owner dropping its request does not abort; only S_ack or
          // the timeout ends the transaction. S_ack has priority over expiry.
          if (S_ack) begin
            S_req <= 1'b0;
            M_ack <= GNT;
            state <= RELEASE;
          end else if (wait_cnt == LAST_WAIT) begin
            S_req <= 1'b0;
            M_err <= GNT;
            state <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RELEASE: begin
          // Hold ownership until the owner withdraws its request; S_ack here
          // is ignored. Returning to IDLE without granting guarantees at
          // least one idle cycle between owners.
          if (!M_req[Select]) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            GNT   <= 3'b000;
            ptr   <= (Select == 2'd2) ? 2'd0 : Select + 2'd1;
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          GNT   <= 3'b000;
          S_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shared_unit_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_shared_unit_arbiter                                          |
// | Purpose  : Self-checking bench for shared_unit_arbiter (TIMEOUT = 4).      |
// |            Expected M_ack/M_err pulses are queued when the stimulus that   |
// |            causes them is driven and compared when the DUT pulses.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shared_unit_arbiter;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] M_req = 3'b000;
  logic       S_ack = 1'b0;
  logic [2:0] M_ack;
  logic [2:0] M_err;
  logic [2:0] GNT;
  logic       S_req;
  logic [1:0] Select;
  logic       BUSY;

  int vectors = 0;
  int miscompares = 0;

  // Expected response queue, packed as {M_err, M_ack}.
  logic [5:0] sb[$];

  shared_unit_arbiter #(.TIMEOUT(TO)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .M_req  (M_req),
    .M_ack  (M_ack),
    .M_err  (M_err),
    .GNT    (GNT),
    .S_req  (S_req),
    .S_ack  (S_ack),
    .Select (Select),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_sreq();
    for (int i = 0; i < 20 && !S_req; i++) tick();
    check("sreq_seen", S_req, 1);
  endtask

  task automatic reset_dut();
    RST   = 1'b1;
    M_req = 3'b000;
    S_ack = 1'b0;
    tick();
    tick();
    check("rst_sreq", S_req, 0);
    check("rst_gnt", GNT, 0);
    check("rst_sel", Select, 0);
    check("rst_busy", BUSY, 0);
    check("rst_resp", {M_err, M_ack}, 0);
    RST = 1'b0;
  endtask

  // Response monitor: every ack/err pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (!RST && (M_ack != 3'b000 || M_err != 3'b000)) begin
      check("ack_err_excl", (M_ack != 3'b000) && (M_err != 3'b000), 0);
      if (sb.size() == 0) begin
        check("unexp_resp", {M_err, M_ack}, 0);
      end else begin
        check("resp", {M_err, M_ack}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] e;
    int         cnt;

    reset_dut();

    // Single requester, master 1, quick S_ack.
    M_req = 3'b010;
    tick();
    check("sreq_lat", S_req, 1);
    check("gnt_m1", GNT, 3'b010);
    check("sel_grant", Select, 1);
    check("busy_serve", BUSY, 1);
    tick();
    check("sreq_hold", S_req, 1);
    check("sel_serve", Select, 1);
    S_ack = 1'b1;
    sb.push_back(6'b000_010);
    tick();
    S_ack = 1'b0;
    check("sreq_drop", S_req, 0);
    check("mack_m1", M_ack, 3'b010);
    check("sel_release", Select, 1);
    M_req = 3'b000;
    tick();
    check("gnt_idle", GNT, 0);
    check("busy_idle", BUSY, 0);
    check("sel_keep", Select, 1);
    check("mack_once", M_ack, 0);
    // S_ack while idle is ignored.
    S_ack = 1'b1;
    tick();
    S_ack = 1'b0;
    check("idle_sack_busy", BUSY, 0);
    check("idle_sack_ack", M_ack, 0);

    // All three request; grants rotate 0, 1, 2 after reset.
    reset_dut();
    M_req = 3'b111;
    for (int m = 0; m < 3; m++) begin
      wait_sreq();
      e = 6'b000_001 << m;
      check("rr_gnt", GNT, e[2:0]);
      check("rr_sel", Select, m);
      tick();
      tick();
      S_ack = 1'b1;
      sb.push_back(e);
      tick();
      S_ack = 1'b0;
      M_req[m] = 1'b0;
      tick();
      check("idle_gap", BUSY, 0);
    end

    // Timeout: master 0, no S_ack; S_req high exactly TO cycles.
    M_req = 3'b001;
    sb.push_back(6'b001_000);
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (S_req) cnt++;
      tick();
    end
    check("sreq_len", cnt, TO);
    check("to_no_ack", M_ack, 0);
    check("to_gnt_hold", GNT, 3'b001);
    M_req = 3'b000;
    tick();
    check("to_idle", BUSY, 0);

    // S_ack on the last SERVE cycle beats the timeout.
    M_req = 3'b001;
    tick();
    check("exp_gnt", GNT, 3'b001);
    tick();
    tick();
    tick();
    S_ack = 1'b1;
    sb.push_back(6'b000_001);
    tick();
    S_ack = 1'b0;
    check("ack_on_expiry", M_ack, 3'b001);
    check("err_on_expiry", M_err, 0);

    // Owner holds its request in RELEASE; stray S_ack gets no response.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) S_ack = 1'b1;
      tick();
      S_ack = 1'b0;
      check("rel_busy", BUSY, 1);
      check("rel_gnt", GNT, 3'b001);
      check("rel_no_ack", M_ack, 0);
    end
    M_req = 3'b000;
    tick();
    check("rel_exit_busy", BUSY, 0);
    check("rel_exit_gnt", GNT, 0);

    // Reset mid-SERVE with owner 2.
    M_req = 3'b100;
    tick();
    check("m2_gnt", GNT, 3'b100);
    tick();
    #2;
    RST   = 1'b1;
    M_req = 3'b000;
    #1;
    check("async_sreq", S_req, 0);
    check("async_gnt", GNT, 0);
    check("async_busy", BUSY, 0);
    tick();
    RST   = 1'b0;
    M_req = 3'b110;
    tick();
    check("post_rst_gnt", GNT, 3'b010);
    check("post_rst_sel", Select, 1);
    S_ack = 1'b1;
    sb.push_back(6'b000_010);
    tick();
    S_ack = 1'b0;
    M_req = 3'b000;
    tick();
    tick();
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
